codec_reg_sequencer: RTL and testbench

//  Parametrised SPI control-port sequencer for WM8731-class audio codecs. After reset it

---
 rtl/codec_pkg.sv | 31 +++
 rtl/codec_spi_tx.sv | 92 +++++++++
 rtl/codec_reg_sequencer.sv | 155 +++++++++++++++
 tb/tb_codec_reg_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// Shared constants, FSM state type and word-packing helper for the codec control port.
package codec_pkg;

    localparam int unsigned ADDR_W_DEF = 7;
    localparam int unsigned DATA_W_DEF = 9;
    localparam int unsigned WORD_W     = ADDR_W_DEF + DATA_W_DEF;

    // WM8731 register map (subset used by init tables and runtime control)
    localparam logic [6:0] R_LINVOL = 7'h00;
    localparam logic [6:0] R_HPVOL  = 7'h02;
    localparam logic [6:0] R_APATH  = 7'h04;
    localparam logic [6:0] R_DPATH  = 7'h05;
    localparam logic [6:0] R_PWR    = 7'h06;
    localparam logic [6:0] R_IFACE  = 7'h07;
    localparam logic [6:0] R_SAMPLE = 7'h08;
    localparam logic [6:0] R_ACTIVE = 7'h09;
    localparam logic [6:0] R_RESET  = 7'h0F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } seq_state_e;

    function automatic logic [WORD_W-1:0] pack_word(input logic [ADDR_W_DEF-1:0] addr,
                                                    input logic [DATA_W_DEF-1:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/codec_spi_tx.sv
// SPI word transmitter: drops CS on load, clocks WORD_W bits MSB first, raises CS after the
// last falling SCK edge. CS low lasts 1 + 2*CLK_DIV*WORD_W cycles.
module codec_spi_tx #(
    parameter int unsigned WORD_W  = 16,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [WORD_W-1:0] word_i,
    output logic              cs_o,
    output logic              sck_o,
    output logic              mosi_o,
    output logic              done_o
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
    localparam int unsigned BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [DIV_W-1:0] DIV_FIRST = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_W - 1);

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              cs_q, cs_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              tick;

    // The load cycle is folded into the first low half (div starts at CLK_DIV, not CLK_DIV-1)
    assign tick   = !cs_q && (div_q == '0);
    assign done_o = tick && sck_q && (bit_q == BIT_LAST);
    assign cs_o   = cs_q;
    assign sck_o  = sck_q;
    assign mosi_o = mosi_q;

    // Next-state for divider, bit counter, shift register and pins
    always_comb begin
        shreg_d = shreg_q;
        div_d   = div_q;
        bit_d   = bit_q;
        cs_d    = cs_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        if (load_i) begin
            cs_d    = 1'b0;
            sck_d   = 1'b0;
            shreg_d = word_i;
            mosi_d  = word_i[WORD_W-1];
            div_d   = DIV_FIRST;
            bit_d   = '0;
        end else if (tick) begin
            div_d = DIV_HALF;
            if (!sck_q) begin
                sck_d = 1'b1;
            end else begin
                sck_d = 1'b0;
                if (bit_q == BIT_LAST) begin
                    cs_d   = 1'b1;
                    mosi_d = 1'b0;
                end else begin
                    shreg_d = shreg_q << 1;
                    mosi_d  = shreg_q[WORD_W-2];
                    bit_d   = bit_q + 1'b1;
                end
            end
        end else if (!cs_q) begin
            div_d = div_q - 1'b1;
        end
    end

    // Pin and counter registers; reset forces idle pins and discards a partial word
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
        end
    end

endmodule

// File: rtl/codec_reg_sequencer.sv
// Codec control-port sequencer: streams the init table after reset/reinit, then serves
// runtime register writes over a valid/ready handshake.
module codec_reg_sequencer #(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned DATA_W     = 9,
    parameter int unsigned NUM_INIT   = 11,
    parameter logic [NUM_INIT*(ADDR_W+DATA_W)-1:0] INIT_TABLE = '0,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 8,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reinit,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              init_done,
    output logic [7:0]        init_index,
    output logic              spi_cs,
    output logic              spi_sck,
    output logic              spi_mosi
);

    import codec_pkg::*;

    localparam int unsigned TX_W  = ADDR_W + DATA_W;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [7:0]       LAST     = 8'(NUM_INIT);

    seq_state_e        state_q, state_d;
    logic [7:0]        index_q, index_d, next_idx;
    logic              done_q, done_d;
    logic              run_q, run_d;
    logic              cur_init_q, cur_init_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              tx_load, tx_done, wr_accept;
    logic [TX_W-1:0]   tx_word;

    function automatic logic [TX_W-1:0] table_entry(input logic [7:0] idx);
        logic [TX_W-1:0] result;
        result = '0;
        for (int unsigned i = 0; i < NUM_INIT; i++) begin
            if (idx == 8'(i)) result = INIT_TABLE[i*TX_W +: TX_W];
        end
        return result;
    endfunction

    assign wr_ready   = (state_q == ST_IDLE) && done_q && !reinit;
    assign wr_accept  = wr_valid && wr_ready;
    assign busy       = (state_q != ST_IDLE);
    assign init_done  = done_q;
    assign init_index = index_q;

    // Next-state, table index and handshake decisions
    // reinit is folded in last: it restarts the table but never cuts a word already in flight,
    // and a word in flight when it arrives no longer advances the index
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        done_d     = done_q;
        run_d      = run_q;
        cur_init_d = cur_init_q;
        gap_d      = gap_q;
        tx_load    = 1'b0;
        tx_word    = '0;
        next_idx   = index_q;
        unique case (state_q)
            ST_IDLE: begin
                if (run_q) begin
                    next_idx   = reinit ? 8'd0 : index_q;
                    tx_load    = 1'b1;
                    tx_word    = table_entry(next_idx);
                    cur_init_d = 1'b1;
                    state_d    = ST_LOAD;
                end else if (wr_accept) begin
                    tx_load    = 1'b1;
                    tx_word    = {wr_addr, wr_data};
                    cur_init_d = 1'b0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (tx_done) begin
                    gap_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else if (cur_init_q && !reinit && (index_q + 8'd1 == LAST)) begin
                    index_d = LAST;
                    done_d  = 1'b1;
                    run_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (run_q || reinit) begin
                    next_idx   = reinit ? 8'd0 : (cur_init_q ? index_q + 8'd1 : index_q);
                    index_d    = next_idx;
                    tx_load    = 1'b1;
                    tx_word    = table_entry(next_idx);
                    cur_init_d = 1'b1;
                    state_d    = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (reinit) begin
            done_d  = 1'b0;
            run_d   = 1'b1;
            index_d = '0;
            if (!tx_load) cur_init_d = 1'b0;
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            index_q    <= '0;
            done_q     <= 1'b0;
            run_q      <= AUTO_START;
            cur_init_q <= 1'b0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            done_q     <= done_d;
            run_q      <= run_d;
            cur_init_q <= cur_init_d;
            gap_q      <= gap_d;
        end
    end

    codec_spi_tx #(
        .WORD_W  (TX_W),
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk    (clk),
        .reset  (reset),
        .load_i (tx_load),
        .word_i (tx_word),
        .cs_o   (spi_cs),
        .sck_o  (spi_sck),
        .mosi_o (spi_mosi),
        .done_o (tx_done)
    );

endmodule

// File: tb/tb_codec_reg_sequencer.sv
// Scoreboard bench: stimulus pushes expected SPI words; negedge monitors decode the pins.
`timescale 1ns/1ps
module tb_codec_reg_sequencer;
    import codec_pkg::*;

    localparam int unsigned NI       = 3;
    localparam int unsigned CD       = 2;
    localparam int unsigned GAP      = 8;
    localparam int unsigned INIT_CYC = 1 + NI * (1 + 2 * CD * 16 + GAP);
    localparam logic [NI*16-1:0] TABLE = {16'h1201, 16'h0C10, 16'h1E00};

    logic [15:0] init_words [NI] = '{16'h1E00, 16'h0C10, 16'h1201};

    logic       clk = 1'b0;
    logic       reset, reinit, wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       wr_ready, busy, init_done, spi_cs, spi_sck, spi_mosi;
    logic [7:0] init_index;
    logic       f_ready, f_busy, f_done, f_cs, f_sck, f_mosi;
    logic [7:0] f_index;

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    codec_reg_sequencer #(
        .ADDR_W(7), .DATA_W(9), .NUM_INIT(NI), .INIT_TABLE(TABLE),
        .CLK_DIV(CD), .GAP_CYCLES(GAP), .AUTO_START(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .reinit(reinit), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .init_done(init_done),
        .init_index(init_index), .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi)
    );

    codec_reg_sequencer #(
        .ADDR_W(7), .DATA_W(9), .NUM_INIT(NI), .INIT_TABLE(TABLE),
        .CLK_DIV(1), .GAP_CYCLES(1), .AUTO_START(1'b1)
    ) dut_fast (
        .clk(clk), .reset(reset), .reinit(1'b0), .wr_valid(1'b0), .wr_ready(f_ready),
        .wr_addr(7'h00), .wr_data(9'h000), .busy(f_busy), .init_done(f_done),
        .init_index(f_index), .spi_cs(f_cs), .spi_sck(f_sck), .spi_mosi(f_mosi)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Main SPI monitor: decode each CS-low window and compare against the scoreboard
    int unsigned mon_bits = 0, mon_frames = 0, m_cslow = 0;
    logic [15:0] m_sh = '0;
    bit          m_act = 0;
    logic        m_psck = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            m_act = 0;
            mon_bits = 0;
        end else if (!spi_cs) begin
            if (!m_act) begin
                m_act = 1; mon_bits = 0; m_cslow = 0; m_sh = '0;
            end
            m_cslow++;
            if (spi_sck && !m_psck) begin
                m_sh = {m_sh[14:0], spi_mosi};
                mon_bits++;
            end
        end else if (m_act) begin
            m_act = 0;
            mon_frames++;
            check("frame_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("frame_word", 32'(m_sh), 32'(exp_q.pop_front()));
                check("frame_bits", mon_bits, 16);
                check("frame_cs_low", m_cslow, 1 + 2 * CD * 16);
            end
        end
        m_psck = spi_sck;
    end

    // Fast-config monitor: init words in order, CS low 33 cycles, frame period 34
    int unsigned f_bits = 0, f_cslow = 0, f_k = 0, f_fall = 0;
    logic [15:0] f_sh = '0;
    bit          f_act = 0;
    logic        f_psck = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            f_act = 0;
            f_k = 0;
        end else if (!f_cs) begin
            if (!f_act) begin
                f_act = 1; f_bits = 0; f_cslow = 0; f_sh = '0;
                if (f_k > 0 && f_k < NI) check("fast_period", cyc - f_fall, 34);
                f_fall = cyc;
            end
            f_cslow++;
            if (f_sck && !f_psck) begin
                f_sh = {f_sh[14:0], f_mosi};
                f_bits++;
            end
        end else if (f_act) begin
            f_act = 0;
            check("fast_frame_expected", 32'(f_k < NI), 1);
            if (f_k < NI) begin
                check("fast_word", 32'(f_sh), 32'(init_words[f_k]));
                check("fast_bits", f_bits, 16);
                check("fast_cs_low", f_cslow, 33);
            end
            f_k++;
        end
        f_psck = f_sck;
    end

    task automatic push_table();
        for (int i = 0; i < NI; i++) exp_q.push_back(init_words[i]);
    endtask

    task automatic wait_init(input string name, input int unsigned exp_cycles, input bit exact);
        int unsigned k = 0;
        bit seen = 0;
        while (!seen && k < 3000) begin
            @(posedge clk); #1;
            k++;
            if (init_done) seen = 1;
        end
        check({name, "_seen"}, 32'(seen), 1);
        if (exact) check(name, k, exp_cycles);
        check({name, "_index"}, 32'(init_index), NI);
    endtask

    task automatic wait_bits(input int unsigned n);
        int unsigned t = 0;
        while (!(m_act && mon_bits >= n) && t < 500) begin
            @(negedge clk); #1;
            t++;
        end
        check("reach_bit", 32'(m_act && mon_bits >= n), 1);
    endtask

    // Presents one write, holding valid until accepted or budget runs out
    task automatic do_write(input logic [6:0] a, input logic [8:0] d, input int unsigned budget,
                            output bit ok, output int unsigned rb);
        ok = 0;
        rb = 0;
        wr_addr = a;
        wr_data = d;
        wr_valid = 1'b1;
        for (int unsigned n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            if (!init_done && wr_ready) rb++;
            if (wr_ready) begin
                ok = 1;
                exp_q.push_back(pack_word(a, d));
            end
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
    endtask

    bit          ok;
    int unsigned rb;
    int unsigned base, t;
    logic [6:0]  ra;
    logic [8:0]  rd;

    initial begin
        reset = 1'b1; reinit = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", 32'(spi_cs), 1);
        check("rst_sck", 32'(spi_sck), 0);
        check("rst_mosi", 32'(spi_mosi), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_init_done", 32'(init_done), 0);
        check("rst_wr_ready", 32'(wr_ready), 0);
        check("rst_init_index", 32'(init_index), 0);
        reset = 1'b0;
        push_table();
        wait_init("init_time", INIT_CYC, 1);

        // Runtime write straight after init: accepted in one cycle
        do_write(R_HPVOL, 9'h07C, 1, ok, rb);
        check("hpvol_accept", 32'(ok), 1);
        check("ready_low_after_accept", 32'(wr_ready), 0);

        // Random runtime writes with random idle spacing
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            ra = 7'($urandom);
            rd = 9'($urandom);
            do_write(ra, rd, 200, ok, rb);
            check("rand_accept", 32'(ok), 1);
            check("rand_ready_low", 32'(wr_ready), 0);
        end

        // reinit mid-SHIFT of a runtime write
        do_write(7'($urandom), 9'($urandom), 200, ok, rb);
        check("pre_reinit_accept", 32'(ok), 1);
        wait_bits(5);
        @(posedge clk); #1;
        reinit = 1'b1;
        @(posedge clk); #1;
        reinit = 1'b0;
        check("reinit_done_clear", 32'(init_done), 0);
        check("reinit_index_zero", 32'(init_index), 0);
        check("reinit_word_in_flight", 32'(busy && !spi_cs), 1);
        push_table();
        wait_init("reinit_init", 0, 0);

        // reinit coincident with a ready handshake, then valid held through the whole init
        @(posedge clk); #1;
        ra = 7'($urandom);
        rd = 9'($urandom);
        wr_addr = ra; wr_data = rd; wr_valid = 1'b1; reinit = 1'b1;
        @(negedge clk);
        check("reinit_blocks_ready", 32'(wr_ready), 0);
        @(posedge clk); #1;
        reinit = 1'b0;
        push_table();
        do_write(ra, rd, 600, ok, rb);
        check("held_accept", 32'(ok), 1);
        check("ready_during_init", rb, 0);

        // reinit during the GAP of the last init entry
        @(posedge clk); #1;
        while (busy) begin @(posedge clk); #1; end
        reinit = 1'b1;
        @(posedge clk); #1;
        reinit = 1'b0;
        push_table();
        base = mon_frames;
        t = 0;
        while (mon_frames < base + NI && t < 1000) begin @(negedge clk); #1; t++; end
        check("reach_last_gap", 32'(mon_frames >= base + NI), 1);
        repeat (2) begin @(posedge clk); #1; end
        reinit = 1'b1;
        @(posedge clk); #1;
        reinit = 1'b0;
        repeat (GAP + 4) begin @(posedge clk); #1; end
        check("gap_reinit_done_low", 32'(init_done), 0);
        push_table();
        wait_init("gap_reinit_init", 0, 0);

        // reset mid-SHIFT of a runtime write
        do_write(7'($urandom), 9'($urandom), 200, ok, rb);
        check("pre_reset_accept", 32'(ok), 1);
        wait_bits(8);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_cs", 32'(spi_cs), 1);
        check("midrst_sck", 32'(spi_sck), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_init_done", 32'(init_done), 0);
        reset = 1'b0;
        exp_q.delete();
        push_table();
        wait_init("rerun_init_time", INIT_CYC, 1);

        // Drain and final state
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 1000) begin @(posedge clk); #1; t++; end
        check("queue_drained", exp_q.size(), 0);
        check("fast_init_done", 32'(f_done), 1);
        check("fast_index", 32'(f_index), NI);
        check("fast_frames", f_k, NI);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
